truth_table_probe: RTL and testbench
====================================

// Module: truth_table_probe
// PURPOSE
//  Reader/characteriser for 3-input logic gate modules. Drives all 8 input rows into a
//  gate under test (GUT), samples its output per row and assembles the 8-bit truth-table
//  code (e.g. 0x4E). Compares the code with an expected value. Sits in the gate-library
//  verification harness: probe_in* -> GUT in1..in3, GUT out -> gate_out.
// PARAMETERS
//  SETTLE   4  cycles each row is driven before the first sample (1..255)
//  SAMPLES  2  consecutive samples per row; all must agree (1..15)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  begin a characterisation run (accepted only in IDLE)
//  abort      in   1  cancel the run in progress
//  expected   in   8  expected truth-table code; sampled when start is accepted
//  gate_out   in   1  output of the GUT
//  probe_in1  out  1  GUT in1 (MSB of row index)
//  probe_in2  out  1  GUT in2
//  probe_in3  out  1  GUT in3 (LSB of row index)
//  busy       out  1  high from the cycle after start is accepted until done
//  done       out  1  one-cycle pulse at the end of a completed run
//  table_code out  8  measured code; held from done until the next accepted start
//  match      out  1  table_code == latched expected; valid with done, held
//  unstable   out  1  some row's samples disagreed; valid with done, held
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, including probe_in*. Internal counters and the
//    latched expected value are cleared.
//  - Reset mid-run: identical to the reset state on the next edge. No done pulse.
//  - Encoding: row k = {in1,in2,in3} maps to table_code bit (7-k). Row 000 is the MSB.
//    Example: rows 000..111 = 0,1,0,0,1,1,1,0 -> 0x4E.
//  - FSM states: IDLE -> DRIVE -> SAMPLE -> (DRIVE on the next row | DONE) -> IDLE.
//  - IDLE: start=1 accepts the run. It latches expected, clears the working code and
//    the unstable accumulator, sets row=0 and goes to DRIVE.
//  - DRIVE: probe_in* = row. Stays SETTLE cycles, then goes to SAMPLE.
//  - SAMPLE: probe_in* still = row. Samples gate_out for SAMPLES cycles. The bit stored
//    is the last sample. Any sample that differs from the row's first sample sets
//    unstable. At the last sample: row==7 goes to DONE, else row+1 and DRIVE.
//  - Row counter is 3 bits. A run always ends after row 7; it never wraps to a 9th row.
//  - DONE (1 cycle): done=1, publishes table_code/match/unstable, busy=0, probe_in*=0,
//    then IDLE.
//  - Latency: done is high exactly 8*(SETTLE+SAMPLES)+1 cycles after the start-accept
//    edge. Default: 49 cycles.
//  - start while busy: ignored. start in the DONE cycle: ignored.
//  - abort while busy: next state IDLE, probe_in*=0, busy=0. No done pulse. table_code,
//    match and unstable keep their previous values. abort has priority over a sample in
//    the same cycle. abort in IDLE: no effect.
//  - start and abort together in IDLE: start wins (abort is meaningful only while busy).
//  - gate_out is in the clk domain (combinational GUT). No synchroniser is used;
//    SETTLE covers propagation.
// STRUCTURE
//  - truth_table_pkg: state enum {IDLE,DRIVE,SAMPLE,DONE}, N_ROWS=8, ROW_W=3,
//    function row_bit(row) returning 7-row.
//  - One sub-module, probe_timer: loadable down-counter with a zero flag. It is shared
//    by DRIVE (load SETTLE-1) and SAMPLE (load SAMPLES-1).
//  - Top level holds the FSM, row counter, code shift/insert register, expected latch
//    and compare.
// TESTING
//  1 GUT model = 0x4E gate, expected=0x4E, start pulse -> done at cycle 49,
//    table_code=0x4E, match=1, unstable=0.
//  2 Same GUT, expected=0x72 -> table_code=0x4E, match=0. Confirms MSB-first row order.
//  3 GUT model toggles gate_out during SAMPLE of row 011 (SAMPLES=2) -> unstable=1,
//    match stays valid, done still at 49.
//  4 abort at cycle 20 -> busy=0 next cycle, no done, probe_in*=0, previous table_code
//    retained. Restart -> normal run.
//  5 rst asserted at cycle 30 -> all outputs 0 next edge. start held high during busy
//    -> exactly one run per accepted start.
//  6 SETTLE=1, SAMPLES=1, constant-1 GUT -> table_code=0xFF, done at cycle 17.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the 3-input gate truth-table probe.
package truth_table_pkg;
    localparam int N_ROWS = 8;
    localparam int ROW_W  = 3;
    localparam int CODE_W = N_ROWS;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    // Row 000 lands in the MSB of the code, row 111 in the LSB.
    function automatic logic [ROW_W-1:0] row_bit(input logic [ROW_W-1:0] row);
        return ROW_W'(N_ROWS - 1) - row;
    endfunction
endpackage

// File: rtl/probe_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module probe_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);
endmodule

// File: rtl/truth_table_probe.sv
// Walks a 3-input gate through all 8 input rows, assembles its truth-table code
// and compares it with a latched expected value.
module truth_table_probe
    import truth_table_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int SAMPLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       gate_out,
    output logic       probe_in1,
    output logic       probe_in2,
    output logic       probe_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_code,
    output logic       match,
    output logic       unstable
);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [7:0] SAMPLE_LOAD = 8'(SAMPLES - 1);

    state_t state_reg, state_next;

    logic [ROW_W-1:0]  row_reg;
    logic [CODE_W-1:0] work_reg;
    logic [CODE_W-1:0] exp_reg;
    logic [CODE_W-1:0] table_code_reg;
    logic [CODE_W-1:0] code_next;
    logic              unst_acc_reg;
    logic              first_reg;
    logic              match_reg;
    logic              unstable_reg;

    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_zero;
    logic [7:0]        tmr_load_value;
    logic [7:0]        tmr_count;

    logic              first_sample;
    logic              sample_bad;
    logic              last_sample;
    logic              run_end;
    logic [ROW_W-1:0]  bit_sel;

    probe_timer #(.WIDTH(8)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .en         (tmr_en),
        .count      (tmr_count),
        .zero       (tmr_zero)
    );

    // Working code with the current row's bit replaced by the live sample.
    assign bit_sel = row_bit(row_reg);
    generate
        for (genvar gi = 0; gi < CODE_W; gi++) begin : g_code
            assign code_next[gi] = (bit_sel == ROW_W'(gi)) ? gate_out : work_reg[gi];
        end
    endgenerate

    assign first_sample = (tmr_count == SAMPLE_LOAD);
    assign sample_bad   = !first_sample && (gate_out != first_reg);
    assign last_sample  = (state_reg == SAMPLE) && !abort && tmr_zero;
    assign run_end      = last_sample && (row_reg == ROW_W'(N_ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        tmr_en         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = DRIVE;
                    tmr_load       = 1'b1;
                    tmr_load_value = SETTLE_LOAD;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (tmr_zero) begin
                    state_next     = SAMPLE;
                    tmr_load       = 1'b1;
                    tmr_load_value = SAMPLE_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (tmr_zero) begin
                    if (run_end) begin
                        state_next = DONE;
                    end else begin
                        state_next     = DRIVE;
                        tmr_load       = 1'b1;
                        tmr_load_value = SETTLE_LOAD;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_reg        <= '0;
            work_reg       <= '0;
            exp_reg        <= '0;
            unst_acc_reg   <= 1'b0;
            first_reg      <= 1'b0;
            table_code_reg <= '0;
            match_reg      <= 1'b0;
            unstable_reg   <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && start) begin
                exp_reg      <= expected;
                work_reg     <= '0;
                unst_acc_reg <= 1'b0;
                row_reg      <= '0;
            end
            if ((state_reg == SAMPLE) && !abort) begin
                if (first_sample) begin
                    first_reg <= gate_out;
                end
                if (sample_bad) begin
                    unst_acc_reg <= 1'b1;
                end
                if (tmr_zero) begin
                    work_reg <= code_next;
                    if (!run_end) begin
                        row_reg <= row_reg + ROW_W'(1);
                    end
                end
            end
            // Published results only change at the end of a completed run.
            if (run_end) begin
                table_code_reg <= code_next;
                match_reg      <= (code_next == exp_reg);
                unstable_reg   <= unst_acc_reg | sample_bad;
            end
        end
    end

    assign busy = (state_reg == DRIVE) || (state_reg == SAMPLE);
    assign done = (state_reg == DONE);
    assign {probe_in1, probe_in2, probe_in3} = busy ? row_reg : '0;
    assign table_code = table_code_reg;
    assign match      = match_reg;
    assign unstable   = unstable_reg;
endmodule

// File: tb/tb_truth_table_probe.sv
// Randomised checks of truth_table_probe against a row-by-row behavioural gate model.
module tb_truth_table_probe;
    localparam int SETTLE  = 4;
    localparam int SAMPLES = 2;
    localparam int PER_ROW = SETTLE + SAMPLES;
    localparam int LAT     = 8 * PER_ROW + 1;
    localparam int LAT_B   = 8 * (1 + 1) + 1;

    logic       clk = 1'b0;
    logic       rst, start, abort, gate_out;
    logic [7:0] expected;
    logic       probe_in1, probe_in2, probe_in3, busy, done, match, unstable;
    logic [7:0] table_code;

    logic       rst_b, start_b, abort_b, gate_b;
    logic [7:0] exp_b;
    logic       pb1, pb2, pb3, busy_b, done_b, match_b, unstable_b;
    logic [7:0] code_b;

    int checks = 0;
    int errors = 0;
    int edge_count = 0;
    int accept_mark = 0;
    logic [7:0] func;
    bit         glitch_en;
    logic [2:0] probe_row;
    logic       glitch_now;
    logic [7:0] last_code;
    logic       last_match, last_unstable;

    always #5 clk = ~clk;
    always @(posedge clk) edge_count <= edge_count + 1;

    // GUT model: row r = {in1,in2,in3} outputs func[7-r]; optional flip on row 011's first sample.
    assign probe_row  = {probe_in1, probe_in2, probe_in3};
    assign glitch_now = glitch_en && busy && (probe_row == 3'd3)
                        && (((edge_count - accept_mark) % PER_ROW) == SETTLE);
    assign gate_out   = func[3'd7 - probe_row] ^ glitch_now;

    truth_table_probe #(.SETTLE(SETTLE), .SAMPLES(SAMPLES)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
        .gate_out(gate_out), .probe_in1(probe_in1), .probe_in2(probe_in2),
        .probe_in3(probe_in3), .busy(busy), .done(done), .table_code(table_code),
        .match(match), .unstable(unstable)
    );

    truth_table_probe #(.SETTLE(1), .SAMPLES(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b), .expected(exp_b),
        .gate_out(gate_b), .probe_in1(pb1), .probe_in2(pb2), .probe_in3(pb3),
        .busy(busy_b), .done(done_b), .table_code(code_b), .match(match_b),
        .unstable(unstable_b)
    );

    task automatic launch(input logic [7:0] exp_v, input bit with_abort, input bit hold);
        @(negedge clk);
        expected = exp_v;
        start    = 1'b1;
        abort    = with_abort;
        @(posedge clk);
        #1;
        accept_mark = edge_count;
        abort       = 1'b0;
        if (!hold) start = 1'b0;
        expected = 8'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int probe_errs);
        cyc = 0;
        probe_errs = 0;
        while (!done && cyc < 200) begin
            if (int'(probe_row) != cyc / PER_ROW) probe_errs++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_run(input string name, input logic [7:0] exp_v, input bit exp_unst);
        int cyc, pe;
        logic exp_match;
        exp_match = (func == exp_v);
        wait_done(cyc, pe);
        $display("run %s func=%02h exp=%02h code=%02h match=%0b unstable=%0b done_cycle=%0d",
                 name, func, exp_v, table_code, match, unstable, cyc + 1);
        checks++; if (cyc + 1 !== LAT) begin errors++; $display("FAIL %s latency got %0d want %0d", name, cyc + 1, LAT); end
        checks++; if (pe !== 0) begin errors++; $display("FAIL %s probe_rows got %0d bad cycles want 0", name, pe); end
        checks++; if (table_code !== func) begin errors++; $display("FAIL %s table_code got %02h want %02h", name, table_code, func); end
        checks++; if (match !== exp_match) begin errors++; $display("FAIL %s match got %0b want %0b", name, match, exp_match); end
        checks++; if (unstable !== exp_unst) begin errors++; $display("FAIL %s unstable got %0b want %0b", name, unstable, exp_unst); end
        checks++; if ({busy, probe_row} !== 4'b0) begin errors++; $display("FAIL %s done_idle got %b want 0000", name, {busy, probe_row}); end
        @(posedge clk);
        #1;
        checks++; if ({done, table_code} !== {1'b0, func}) begin errors++; $display("FAIL %s after_done got %b want %b", name, {done, table_code}, {1'b0, func}); end
        last_code = func;
        last_match = exp_match;
        last_unstable = exp_unst;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; expected = 8'h00; func = 8'h00; glitch_en = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; exp_b = 8'h00; gate_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst_b = 1'b0;
        checks++; if ({probe_row, busy, done, table_code, match, unstable} !== 15'b0) begin
            errors++; $display("FAIL reset outputs got %b want 0", {probe_row, busy, done, table_code, match, unstable}); end
        checks++; if ({pb1, pb2, pb3, busy_b, done_b, code_b, match_b, unstable_b} !== 15'b0) begin
            errors++; $display("FAIL reset_b outputs got %b want 0", {pb1, pb2, pb3, busy_b, done_b, code_b, match_b, unstable_b}); end
    endtask

    task automatic test_basic;
        func = 8'h4E;
        launch(8'h4E, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic busy got %0b want 1", busy); end
        check_run("basic", 8'h4E, 1'b0);
    endtask

    task automatic test_row_order;
        func = 8'h4E;
        launch(8'h72, 1'b0, 1'b0);
        check_run("row_order", 8'h72, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            func = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? func : 8'($urandom);
            launch(e, 1'b0, 1'b0);
            check_run("random", e, 1'b0);
        end
    endtask

    task automatic test_glitch;
        func = 8'($urandom);
        glitch_en = 1'b1;
        launch(func, 1'b0, 1'b0);
        check_run("glitch", func, 1'b1);
        glitch_en = 1'b0;
    endtask

    task automatic test_abort;
        int cyc, n_done;
        logic [7:0] e;
        func = 8'($urandom);
        launch(8'($urandom), 1'b0, 1'b0);
        cyc = 0;
        while (cyc < 19) begin @(posedge clk); #1; cyc++; end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        $display("run abort busy=%0b probe=%0d code=%02h", busy, probe_row, table_code);
        checks++; if ({busy, done, probe_row} !== 5'b0) begin errors++; $display("FAIL abort outputs got %b want 00000", {busy, done, probe_row}); end
        checks++; if ({table_code, match, unstable} !== {last_code, last_match, last_unstable}) begin
            errors++; $display("FAIL abort held got %b want %b", {table_code, match, unstable}, {last_code, last_match, last_unstable}); end
        n_done = 0;
        for (int i = 0; i < 60; i++) begin @(posedge clk); #1; if (done || busy) n_done++; end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL abort no_done got %0d active cycles want 0", n_done); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++; if ({busy, table_code} !== {1'b0, last_code}) begin errors++; $display("FAIL abort_idle got %b want %b", {busy, table_code}, {1'b0, last_code}); end
        func = 8'($urandom);
        e = func;
        launch(e, 1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_abort_idle busy got %0b want 1", busy); end
        check_run("restart", e, 1'b0);
    endtask

    task automatic test_reset_midrun;
        int cyc, n_busy;
        logic [7:0] e;
        func = 8'($urandom);
        launch(func, 1'b0, 1'b0);
        cyc = 0;
        while (cyc < 29) begin @(posedge clk); #1; cyc++; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("run reset_midrun busy=%0b code=%02h", busy, table_code);
        checks++; if ({probe_row, busy, done, table_code, match, unstable} !== 15'b0) begin
            errors++; $display("FAIL reset_midrun outputs got %b want 0", {probe_row, busy, done, table_code, match, unstable}); end
        func = 8'($urandom);
        e = func;
        launch(e, 1'b0, 1'b1);
        check_run("held_start", e, 1'b0);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done busy got %0b want 0", busy); end
        n_busy = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (busy || done) n_busy++; end
        checks++; if (n_busy !== 0) begin errors++; $display("FAIL one_run_per_start got %0d active cycles want 0", n_busy); end
    endtask

    task automatic test_min_settle;
        int cyc;
        logic [7:0] e;
        logic want_match;
        for (int k = 0; k < 2; k++) begin
            e = (k == 0) ? 8'hFF : 8'h0F;
            want_match = (e == 8'hFF);
            @(negedge clk);
            exp_b = e;
            start_b = 1'b1;
            @(posedge clk);
            #1;
            start_b = 1'b0;
            cyc = 0;
            while (!done_b && cyc < 100) begin @(posedge clk); #1; cyc++; end
            $display("run min_settle exp=%02h code=%02h match=%0b done_cycle=%0d", e, code_b, match_b, cyc + 1);
            checks++; if (cyc + 1 !== LAT_B) begin errors++; $display("FAIL min_settle latency got %0d want %0d", cyc + 1, LAT_B); end
            checks++; if ({code_b, match_b, unstable_b} !== {8'hFF, want_match, 1'b0}) begin
                errors++; $display("FAIL min_settle result got %b want %b", {code_b, match_b, unstable_b}, {8'hFF, want_match, 1'b0}); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_row_order();
        test_random();
        test_glitch();
        test_abort();
        test_reset_midrun();
        test_min_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
